// File: rtl/projector_scheduler.sv
// Point-rate sequencer for the laser projector: picks one of three point sources,
// switches only at frame boundaries and inserts laser-off blanking points.
module projector_scheduler #(
  parameter int CLK_DIV     = 675,
  parameter int BLANK_DWELL = 4,
  parameter int UF_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      sel_src,
  input  logic [2:0]      src_valid,
  input  logic [95:0]     src_data,
  input  logic [2:0]      src_last,
  output logic [2:0]      src_ack,
  output logic            update,
  output logic [31:0]     data_out,
  output logic [1:0]      active_src,
  output logic            frame_done,
  output logic [UF_W-1:0] underflow_cnt
);

  localparam int CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int DW_W  = (BLANK_DWELL < 1) ? 1 : $clog2(BLANK_DWELL + 1);
  localparam logic [2:0] ENTER_STATE = (BLANK_DWELL == 0) ? 3'd2 : 3'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, RUN = 2'd2} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DW_W-1:0]  dwell_reg;
  logic [23:0]      last_xy_reg;
  logic             tick;

  logic [31:0] src_pt [3];
  logic        cur_valid;
  logic        cur_last;
  logic [31:0] cur_pt;
  logic [23:0] target_xy;
  logic [2:0]  cur_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_split
      assign src_pt[gi] = src_data[32*gi +: 32];
    end
  endgenerate

  assign tick = (cnt_reg == CNT_W'(CLK_DIV - 1));

  // Head of the granted source; park (3) never presents a point.
  always_comb begin
    cur_valid  = 1'b0;
    cur_last   = 1'b0;
    cur_pt     = 32'd0;
    cur_onehot = 3'b000;
    case (active_src)
      2'd0: begin cur_valid = src_valid[0]; cur_last = src_last[0]; cur_pt = src_pt[0]; cur_onehot = 3'b001; end
      2'd1: begin cur_valid = src_valid[1]; cur_last = src_last[1]; cur_pt = src_pt[1]; cur_onehot = 3'b010; end
      2'd2: begin cur_valid = src_valid[2]; cur_last = src_last[2]; cur_pt = src_pt[2]; cur_onehot = 3'b100; end
      default: ;
    endcase
    target_xy = cur_valid ? cur_pt[31:8] : last_xy_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dwell_reg     <= '0;
      last_xy_reg   <= '0;
      src_ack       <= '0;
      update        <= 1'b0;
      data_out      <= '0;
      active_src    <= '0;
      frame_done    <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      update     <= 1'b0;
      src_ack    <= '0;
      frame_done <= 1'b0;
      cnt_reg    <= tick ? '0 : cnt_reg + 1'b1;

      if (tick) begin
        case (state_reg)
          IDLE: begin
            if (enable) begin
              active_src <= sel_src;
              dwell_reg  <= DW_W'(BLANK_DWELL);
              state_reg  <= state_t'(ENTER_STATE[1:0]);
            end
          end

          BLANK: begin
            if (!enable) begin
              update    <= 1'b1;
              data_out  <= {last_xy_reg, 8'h00};
              state_reg <= IDLE;
            end else begin
              // Blank at the new source's first position so the galvos settle there.
              update      <= 1'b1;
              data_out    <= {target_xy, 8'h00};
              last_xy_reg <= target_xy;
              dwell_reg   <= dwell_reg - 1'b1;
              if (dwell_reg <= DW_W'(1))
                state_reg <= RUN;
            end
          end

          RUN: begin
            if (!enable) begin
              update    <= 1'b1;
              data_out  <= {last_xy_reg, 8'h00};
              state_reg <= IDLE;
            end else if (cur_valid) begin
              update      <= 1'b1;
              data_out    <= cur_pt;
              last_xy_reg <= cur_pt[31:8];
              src_ack     <= cur_onehot;
              if (cur_last) begin
                frame_done <= 1'b1;
                if (sel_src != active_src) begin
                  active_src <= sel_src;
                  dwell_reg  <= DW_W'(BLANK_DWELL);
                  state_reg  <= state_t'(ENTER_STATE[1:0]);
                end
              end
            end else begin
              update   <= 1'b1;
              data_out <= {last_xy_reg, 8'h00};
              if (active_src == 2'd3) begin
                // Park has no frames, so a new request is granted without waiting.
                if (sel_src != 2'd3) begin
                  active_src <= sel_src;
                  dwell_reg  <= DW_W'(BLANK_DWELL);
                  state_reg  <= state_t'(ENTER_STATE[1:0]);
                end
              end else if (underflow_cnt != '1) begin
                underflow_cnt <= underflow_cnt + 1'b1;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_projector_scheduler.sv
// Directed bench for projector_scheduler: CLK_DIV=8, BLANK_DWELL=4, UF_W=4.
module tb_projector_scheduler;

  localparam int CLK_DIV = 8;
  localparam int UF_W    = 4;

  localparam logic [31:0] PT_A    = {12'h123, 12'h456, 3'b111, 5'd0};
  localparam logic [31:0] PT_B    = {12'hABC, 12'h0DE, 3'b101, 5'd0};
  localparam logic [31:0] BLANK_A = {12'h123, 12'h456, 8'h00};
  localparam logic [31:0] BLANK_B = {12'hABC, 12'h0DE, 8'h00};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic [1:0]      sel_src = 2'd2;
  logic [2:0]      src_valid = 3'b101;
  logic [95:0]     src_data;
  logic [2:0]      src_last = 3'b000;
  logic [2:0]      src_ack;
  logic            update;
  logic [31:0]     data_out;
  logic [1:0]      active_src;
  logic            frame_done;
  logic [UF_W-1:0] underflow_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  projector_scheduler #(.CLK_DIV(CLK_DIV), .BLANK_DWELL(4), .UF_W(UF_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sel_src(sel_src),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ack(src_ack), .update(update), .data_out(data_out),
    .active_src(active_src), .frame_done(frame_done), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where update is high; got=0 if none within budget.
  task automatic wait_update(input int budget, output bit got, output int at);
    got = 0;
    at  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (update) begin
        got = 1;
        at  = cyc;
        return;
      end
    end
  endtask

  task automatic expect_point(input string tag, input logic [31:0] pt, input logic [2:0] ack);
    bit got;
    int at;
    wait_update(3 * CLK_DIV, got, at);
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_data"}, data_out, pt);
    check({tag, "_ack"}, 32'(src_ack), 32'(ack));
    $display("point %s: data=%h ack=%b act=%0d fd=%b uf=%0d", tag, data_out, src_ack,
             active_src, frame_done, underflow_cnt);
  endtask

  initial begin
    bit got;
    int at, prev, rel;
    src_data = {PT_A, 32'h0, PT_B};

    repeat (3) @(negedge clk);
    check("rst_update", 32'(update), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_ack", 32'(src_ack), 32'd0);
    check("rst_active", 32'(active_src), 32'd0);
    check("rst_uf", 32'(underflow_cnt), 32'd0);
    reset = 1'b0;
    rel = cyc;

    // 1: start-up blanking on ILDA, then first lit point
    wait_update(3 * CLK_DIV, got, at);
    check("t1_first_seen", 32'(got), 32'd1);
    check("t1_first_cycle", 32'(at - rel), 32'd16);
    check("t1_active", 32'(active_src), 32'd2);
    check("t1_b0_data", data_out, BLANK_A);
    check("t1_b0_ack", 32'(src_ack), 32'd0);
    prev = at;
    for (int i = 1; i < 4; i++) begin
      wait_update(3 * CLK_DIV, got, at);
      check("t1_period", 32'(at - prev), 32'(CLK_DIV));
      check("t1_blank", data_out, BLANK_A);
      check("t1_blank_ack", 32'(src_ack), 32'd0);
      prev = at;
    end
    expect_point("t1_lit", PT_A, 3'b100);

    // 2: mid-frame request is deferred to the frame boundary
    sel_src = 2'd0;
    expect_point("t2_mid", PT_A, 3'b100);
    check("t2_mid_active", 32'(active_src), 32'd2);
    check("t2_mid_fd", 32'(frame_done), 32'd0);
    src_last = 3'b100;
    expect_point("t2_last", PT_A, 3'b100);
    check("t2_fd", 32'(frame_done), 32'd1);
    check("t2_active", 32'(active_src), 32'd0);
    src_last = 3'b000;
    for (int i = 0; i < 4; i++) expect_point("t2_blank", BLANK_B, 3'b000);
    expect_point("t2_lit", PT_B, 3'b001);

    // 3: three underflow ticks on the granted source
    src_valid = 3'b100;
    for (int i = 0; i < 3; i++) expect_point("t3_uf", BLANK_B, 3'b000);
    check("t3_uf_cnt", 32'(underflow_cnt), 32'd3);
    src_valid = 3'b101;
    expect_point("t3_resume", PT_B, 3'b001);

    // 4: counter saturates at 15
    src_valid = 3'b100;
    for (int i = 0; i < 12; i++) expect_point("t4_uf", BLANK_B, 3'b000);
    check("t4_uf_15", 32'(underflow_cnt), 32'd15);
    expect_point("t4_uf_sat", BLANK_B, 3'b000);
    check("t4_uf_hold", 32'(underflow_cnt), 32'd15);
    src_valid = 3'b101;
    expect_point("t4_resume", PT_B, 3'b001);

    // 5: enable drop beats a valid point, then the stream stops
    enable = 1'b0;
    expect_point("t5_off", BLANK_B, 3'b000);
    wait_update(3 * CLK_DIV, got, at);
    check("t5_stopped", 32'(got), 32'd0);

    // 6: reset with an acked point on the outputs
    enable = 1'b1;
    for (int i = 0; i < 4; i++) expect_point("t6_blank", BLANK_B, 3'b000);
    expect_point("t6_lit", PT_B, 3'b001);
    reset = 1'b1;
    #1;
    check("t6_rst_update", 32'(update), 32'd0);
    check("t6_rst_ack", 32'(src_ack), 32'd0);
    check("t6_rst_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    wait_update(4 * CLK_DIV, got, at);
    check("t6_restart_seen", 32'(got), 32'd1);
    check("t6_restart_window", 32'((at - rel) >= CLK_DIV && (at - rel) <= 2 * CLK_DIV), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
